ex_mdu: RTL and testbench
=========================

// Module: ex_mdu
// PURPOSE
//   Iterative RV32M multiply/divide unit beside the single-cycle execute ALU.
//   Takes R-type funct7=0000001 ops issued by the execute stage through a
//   valid/ready handshake and returns the rd write-back value after a
//   multi-cycle shift-add (MUL*) or restoring-divide (DIV*/REM*) sequence.
//   The execute stage stalls issue while in_ready is low.
//   flush cancels the in-flight op on a taken branch or jump.
// PARAMETERS
//   XLEN        32  operand/result width; must be even and >= 8
//   EARLY_OUT   1   1: div-by-zero and signed overflow finish in 1 cycle;
//                   0: always run XLEN iterations
// PORTS
//   clk          in   1     clock, rising edge
//   rst          in   1     asynchronous, active-high reset
//   flush        in   1     abandon current op, return to IDLE
//   in_valid     in   1     op presented
//   in_ready     out  1     unit can accept (state==IDLE)
//   in_funct3    in   3     RV32M funct3 (000 MUL .. 111 REMU)
//   in_op_a      in   XLEN  rs1 value
//   in_op_b      in   XLEN  rs2 value
//   in_rd        in   5     destination register index
//   out_valid    out  1     result available
//   out_ready    in   1     write-back consumes result
//   out_data     out  XLEN  result
//   out_rd       out  5     destination index of result
//   busy         out  1     state != IDLE
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, out_valid=0, out_data=0, out_rd=0,
//   counter=0, busy=0. in_ready=1 once rst deasserts.
// - FSM: IDLE -> CALC (accept = in_valid & in_ready) -> DONE -> IDLE (out_valid & out_ready).
//   - IDLE -> DONE directly when EARLY_OUT=1 and the op is a special case.
//   - out_valid = (state==DONE). out_data/out_rd are stable while out_valid=1 and out_ready=0.
// - Capture at accept: funct3, rd, |a|, |b|, result-sign flags.
//   - Signedness: MULH both signed; MULHSU a signed, b unsigned; MULHU, DIVU, REMU unsigned.
// - CALC runs exactly XLEN cycles via counter 0..XLEN-1. Accept-to-out_valid latency is XLEN+1 cycles.
// - MUL: 2*XLEN-bit shift-add product of the magnitudes, negated if the sign flags differ.
//   - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
// - DIV: restoring division of the magnitudes.
//   - Quotient is negated if the sign flags differ; remainder takes the sign of the dividend.
// - Divide by zero (b==0): quotient = all ones; remainder = a. Applies signed and unsigned.
// - Signed overflow (DIV/REM, a = 1<<(XLEN-1), b = all ones): quotient = a; remainder = 0.
// - Special cases latency: 1 cycle (EARLY_OUT=1) or XLEN+1 cycles with the same values (EARLY_OUT=0).
// - in_ready=0 in CALC and DONE. No accept occurs in the same cycle as a result handoff.
// - flush (highest priority after rst): next state IDLE; out_valid drops next cycle.
//   - A result pending in DONE is discarded. flush with in_valid in IDLE does not accept.
// - rst asserted mid-CALC aborts immediately. No partial result is ever presented.
// - Unknown funct3 cannot occur (3-bit field, all 8 codes defined).
// STRUCTURE
// - define/inst.v: INST_FUNCT7_MULDIV (7'b0000001) and INST_FUNCT3_MUL, _MULH,
//   _MULHSU, _MULHU, _DIV, _DIVU, _REM, _REMU.
// - define/const.v: state encodings MDU_IDLE/MDU_CALC/MDU_DONE, plus the existing XLEN_WIDTH, true, false.
// - Sub-module ex_mdu_sign: combinational operand conditioning.
//   - Maps (funct3, a, b) to magnitudes, sign flags and the special-case flags.
//   - Shared by the mul and div paths. The iteration datapath stays in ex_mdu.
// TESTING (XLEN=32 unless noted)
// 1. MUL 7 x -3 -> out_data 0xFFFFFFEB, out_valid 33 cycles after accept; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
// 2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
// 3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// 4. DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//    Each special case: out_valid 1 cycle after accept with EARLY_OUT=1, 33 cycles with EARLY_OUT=0.
// 5. Backpressure: out_ready=0 for 10 cycles in DONE -> out_data/out_rd stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
// 6. flush at CALC cycle 5 -> IDLE next cycle, no out_valid; rst pulse mid-CALC -> outputs 0 asynchronously; the next op computes correctly.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package ex_mdu_pkg;

  localparam int XLEN_WIDTH = 32;

  localparam logic [6:0] INST_FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] INST_FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] INST_FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] INST_FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] INST_FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] INST_FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] INST_FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] INST_FUNCT3_REM    = 3'b110;
  localparam logic [2:0] INST_FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // within the divide family funct3[1] selects remainder over quotient
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/ex_mdu_sign.sv
// Operand conditioning: magnitudes, result-sign flags and divide special cases.
module ex_mdu_sign
  import ex_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_WIDTH
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_q,
  output logic            neg_r,
  output logic            div_zero,
  output logic            div_ovf
);

  logic a_sgn, b_sgn, sa, sb, sdiv;

  // decide which operands are interpreted as signed and strip their signs
  always_comb begin
    sdiv  = (funct3 == INST_FUNCT3_DIV) || (funct3 == INST_FUNCT3_REM);
    a_sgn = (funct3 == INST_FUNCT3_MULH) || (funct3 == INST_FUNCT3_MULHSU) || sdiv;
    b_sgn = (funct3 == INST_FUNCT3_MULH) || sdiv;
    sa    = a_sgn & op_a[XLEN-1];
    sb    = b_sgn & op_b[XLEN-1];
    // the most negative value maps to itself, which is its correct unsigned magnitude
    mag_a = sa ? (~op_a + 1'b1) : op_a;
    mag_b = sb ? (~op_b + 1'b1) : op_b;
    neg_q = sa ^ sb;
    neg_r = sa;
    div_zero = is_div(funct3) && (op_b == '0);
    div_ovf  = sdiv && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN      = XLEN_WIDTH,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_op_a,
  input  logic [XLEN-1:0] in_op_b,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e state, state_nx;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, dvs;      // hi:lo = product / remainder:quotient, dvs = other operand
  logic [2:0]      f3_q;
  logic            neg_q_q, neg_r_q, spec_q;
  logic [XLEN-1:0] spec_res_q;

  logic [XLEN-1:0] s_mag_a, s_mag_b;
  logic            s_neg_q, s_neg_r, s_div0, s_ovf;

  logic            accept, early, last;
  logic [XLEN-1:0] spec_res;
  logic [XLEN:0]   mul_sum, div_sh, div_df;
  logic [XLEN-1:0] hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] calc_res;

  ex_mdu_sign #(.XLEN(XLEN)) u_sign (
    .funct3   (in_funct3),
    .op_a     (in_op_a),
    .op_b     (in_op_b),
    .mag_a    (s_mag_a),
    .mag_b    (s_mag_b),
    .neg_q    (s_neg_q),
    .neg_r    (s_neg_r),
    .div_zero (s_div0),
    .div_ovf  (s_ovf)
  );

  assign in_ready  = (state == MDU_IDLE);
  assign busy      = (state != MDU_IDLE);
  assign out_valid = (state == MDU_DONE);
  assign accept    = in_valid & in_ready & ~flush;
  assign early     = EARLY_OUT && (s_div0 || s_ovf);
  assign last      = (state == MDU_CALC) && (cnt == CW'(XLEN-1));

  // special-case result straight from the raw operands
  always_comb begin
    spec_res = s_div0 ? '1 : in_op_a;
    if (is_rem(in_funct3))
      spec_res = s_div0 ? in_op_a : '0;
  end

  // one shift-add or restoring-subtract step, plus final sign fix-up
  always_comb begin
    mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? dvs : '0)};
    div_sh  = {hi, lo[XLEN-1]};
    div_df  = div_sh - {1'b0, dvs};
    if (is_div(f3_q)) begin
      if (!div_df[XLEN]) begin
        hi_nx = div_df[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = div_sh[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q_q ? (~prod + 1'b1) : prod;
    if (is_div(f3_q))
      calc_res = is_rem(f3_q) ? (neg_r_q ? (~hi_nx + 1'b1) : hi_nx)
                              : (neg_q_q ? (~lo_nx + 1'b1) : lo_nx);
    else
      calc_res = (f3_q == INST_FUNCT3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  // next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      MDU_IDLE: if (accept) state_nx = early ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (last) state_nx = MDU_DONE;
      MDU_DONE: if (out_ready) state_nx = MDU_IDLE;
      default:  state_nx = MDU_IDLE;
    endcase
    if (flush) state_nx = MDU_IDLE;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nx;
  end

  // operand capture, iteration and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      dvs        <= '0;
      f3_q       <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      out_data   <= '0;
      out_rd     <= '0;
    end else if (accept) begin
      cnt        <= '0;
      hi         <= '0;
      lo         <= s_mag_a;
      dvs        <= s_mag_b;
      f3_q       <= in_funct3;
      neg_q_q    <= s_neg_q;
      neg_r_q    <= s_neg_r;
      spec_q     <= s_div0 | s_ovf;
      spec_res_q <= spec_res;
      out_rd     <= in_rd;
      if (early) out_data <= spec_res;
    end else if (state == MDU_CALC && !flush) begin
      cnt <= cnt + CW'(1);
      hi  <= hi_nx;
      lo  <= lo_nx;
      // a special case held for the full run still reports the fixed value
      if (last) out_data <= spec_q ? spec_res_q : calc_res;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: directed and random ops on an early-out and a full-length instance.
module tb_ex_mdu;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [2:0] in_funct3 = '0;
  logic [31:0] in_op_a = '0, in_op_b = '0;
  logic [4:0] in_rd = '0;

  logic in_ready1, out_valid1, busy1, in_ready0, out_valid0, busy0;
  logic [31:0] out_data1, out_data0;
  logic [4:0] out_rd1, out_rd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_mdu #(.XLEN(XLEN), .EARLY_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_funct3(in_funct3), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_rd(in_rd),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_rd(out_rd1), .busy(busy1));

  ex_mdu #(.XLEN(XLEN), .EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_funct3(in_funct3), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_rd(in_rd),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_rd(out_rd0), .busy(busy0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference: 64-bit arithmetic on the architectural definitions
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] as64, bs64, au64, bu64, p;
    int sa, sb;
    as64 = {{32{a[31]}}, a};
    bs64 = {{32{b[31]}}, b};
    au64 = {32'd0, a};
    bu64 = {32'd0, b};
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = as64 * bs64; return p[31:0];  end
      3'd1: begin p = as64 * bs64; return p[63:32]; end
      3'd2: begin p = as64 * bu64; return p[63:32]; end
      3'd3: begin p = au64 * bu64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // issue one op with out_ready high and check value, rd and latency on both instances
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    logic g1, g0;
    int lat, l1, l0;
    logic [31:0] d1, d0;
    logic [4:0] r1, r0;
    logic [31:0] exp;
    exp = ref_mdu(f, a, b);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_funct3 = f; in_op_a = a; in_op_b = b; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0;
    g1 = 0; g0 = 0; lat = 1; l1 = -1; l0 = -1;
    d1 = '0; d0 = '0; r1 = '0; r0 = '0;
    for (int i = 0; i < 40 && !(g1 && g0); i++) begin
      if (!g1 && out_valid1) begin g1 = 1; l1 = lat; d1 = out_data1; r1 = out_rd1; end
      if (!g0 && out_valid0) begin g0 = 1; l0 = lat; d0 = out_data0; r0 = out_rd0; end
      if (!(g1 && g0)) begin @(negedge clk); lat++; end
    end
    chk({tag, "_data_e1"}, d1, exp);
    chk({tag, "_data_e0"}, d0, exp);
    chk({tag, "_rd"}, {27'd0, r1}, {27'd0, rd});
    chk({tag, "_lat_e1"}, l1, is_special(f, a, b) ? 32'd1 : 32'd33);
    chk({tag, "_lat_e0"}, l0, 32'd33);
  endtask

  initial begin
    int seen;
    logic [2:0] rf;
    logic [31:0] ra, rb;

    // reset state
    #3;
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("rst_out_data", out_data1, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready1}, 32'd1);

    // directed arithmetic
    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd8);
    run_op("div_5_0", 3'd4, 32'd5, 32'd0, 5'd9);
    run_op("remu_5_0", 3'd7, 32'd5, 32'd0, 5'd10);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

    // random ops, biased toward the divide corner cases
    for (int n = 0; n < 24; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
        3: rb = $urandom_range(0, 15) - 8;
        default: ;
      endcase
      run_op("rand", rf, ra, rb, 5'($urandom_range(0, 31)));
    end

    // backpressure: result held stable while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_funct3 = 3'd0; in_op_a = 32'd123; in_op_b = 32'd456; in_rd = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !out_valid1; i++) @(negedge clk);
    chk("bp_valid", {31'd0, out_valid1}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_data", out_data1, 32'd56088);
      chk("bp_rd", {27'd0, out_rd1}, 32'd9);
      chk("bp_in_ready", {31'd0, in_ready1}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid1}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready1}, 32'd1);

    // flush at CALC count 5
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'd5; in_op_a = 32'd1000; in_op_b = 32'd3; in_rd = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_e1", {31'd0, busy1}, 32'd0);
    chk("flush_busy_e0", {31'd0, busy0}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready1}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid1 || out_valid0) seen++;
      @(negedge clk);
    end
    chk("flush_no_result", seen, 32'd0);

    // flush together with in_valid in IDLE must not accept
    flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'd0; in_op_a = 32'd2; in_op_b = 32'd2;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_noaccept", {31'd0, busy1}, 32'd0);

    // flush discards a pending result in DONE
    out_ready = 1'b0;
    in_valid = 1'b1; in_funct3 = 3'd0; in_op_a = 32'd5; in_op_b = 32'd6; in_rd = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid1; i++) @(negedge clk);
    chk("done_valid", {31'd0, out_valid1}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush_valid", {31'd0, out_valid1}, 32'd0);
    chk("done_flush_ready", {31'd0, in_ready1}, 32'd1);
    out_ready = 1'b1;

    // reset pulse mid-CALC clears outputs asynchronously
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'd0; in_op_a = 32'd11; in_op_b = 32'd13; in_rd = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_data", out_data1, 32'd0);
    chk("arst_rd", {27'd0, out_rd1}, 32'd0);
    chk("arst_busy", {31'd0, busy1}, 32'd0);
    chk("arst_valid", {31'd0, out_valid1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_mulh", 3'd1, 32'hFFFF_FF00, 32'd1000, 5'd17);
    run_op("post_rst_rem", 3'd6, 32'd77, 32'hFFFF_FFF6, 5'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
